// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared state encodings, limits and helpers for the display arbiter
package seg_disp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;
  localparam logic [19:0] DATA_MAX = 20'd999_999;
  localparam int NUM_SRC = 3;
  function automatic logic [19:0] clamp(input logic [19:0] v);
    return v > DATA_MAX ? DATA_MAX : v;
  endfunction
endpackage

// File: rtl/seg_rr_pick.sv
// seg_rr_pick: combinational round-robin picker searching last+1, last+2, last (mod 3)
module seg_rr_pick
  import seg_disp_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               found
);
  logic [1:0] n1, n2;
  always_comb begin
    n1 = last == 2'd2 ? 2'd0 : last + 2'd1;
    n2 = n1 == 2'd2 ? 2'd0 : n1 + 2'd1;
    winner = req[n1] ? n1 : req[n2] ? n2 : last;
    found = |req;
  end
endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin sharing of one seg_dynamic display with dwell and blanking
module seg_disp_arbiter
  import seg_disp_pkg::*;
#(
  parameter logic [25:0] CNT_MAX   = 26'd49_999_999,
  parameter logic [15:0] BLANK_MAX = 16'd4_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [19:0]        data_0,
  input  logic [19:0]        data_1,
  input  logic [19:0]        data_2,
  input  logic [5:0]         point_0,
  input  logic [5:0]         point_1,
  input  logic [5:0]         point_2,
  input  logic               sign_0,
  input  logic               sign_1,
  input  logic               sign_2,
  output logic [19:0]        data,
  output logic [5:0]         point,
  output logic               sign,
  output logic               seg_en,
  output logic [NUM_SRC-1:0] grant
);
  state_t      state;
  logic [25:0] dwell_cnt;
  logic [15:0] blank_cnt;
  logic [1:0]  last, winner, src;
  logic [2:0]  own;
  logic        found, other, dwell_done, blank_done, start, hold, show;
  logic [19:0] src_data;
  logic [5:0]  src_point;
  logic        src_sign;

  seg_rr_pick u_pick (.req(req), .last(last), .winner(winner), .found(found));

  // start: a new owner is granted; hold: the current owner keeps the display
  always_comb begin
    own = 3'b001 << last;
    other = |(req & ~own);
    dwell_done = dwell_cnt == CNT_MAX;
    blank_done = blank_cnt == BLANK_MAX;
    start = found && (state == IDLE || (state == BLANK && blank_done));
    hold = state == SHOW && req[last] && !(dwell_done && other);
    show = start || hold;
    src = hold ? last : winner;
    src_data = src == 2'd0 ? data_0 : src == 2'd1 ? data_1 : data_2;
    src_point = src == 2'd0 ? point_0 : src == 2'd1 ? point_1 : point_2;
    src_sign = src == 2'd0 ? sign_0 : src == 2'd1 ? sign_1 : sign_2;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      last <= 2'd2;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      seg_en <= 1'b0;
      grant <= '0;
      data <= '0;
      point <= '0;
      sign <= 1'b0;
    end else begin
      state <= show ? SHOW : state == SHOW ? (other ? BLANK : IDLE) :
               (state == BLANK && !blank_done) ? BLANK : IDLE;
      last <= start ? winner : last;
      dwell_cnt <= start ? '0 : (hold && !dwell_done) ? dwell_cnt + 26'd1 : dwell_cnt;
      blank_cnt <= (state == BLANK && !blank_done) ? blank_cnt + 16'd1 : '0;
      seg_en <= show;
      grant <= show ? 3'b001 << src : '0;
      data <= show ? clamp(src_data) : '0;
      point <= show ? src_point : '0;
      sign <= show ? src_sign : 1'b0;
    end
  end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed checks of arbitration, dwell, blanking, clamp and reset
module tb_seg_disp_arbiter;
  logic        sys_clk, sys_rst_n;
  logic [2:0]  req;
  logic [19:0] data_0, data_1, data_2, data;
  logic [5:0]  point_0, point_1, point_2, point;
  logic        sign_0, sign_1, sign_2, sign, seg_en;
  logic [2:0]  grant;
  int          total = 0;
  int          bad = 0;

  seg_disp_arbiter #(.CNT_MAX(26'd5), .BLANK_MAX(16'd2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .point_0(point_0), .point_1(point_1), .point_2(point_2),
    .sign_0(sign_0), .sign_1(sign_1), .sign_2(sign_2),
    .data(data), .point(point), .sign(sign), .seg_en(seg_en), .grant(grant)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic en, input logic [2:0] gr,
                     input logic [19:0] d, input logic [5:0] p, input logic s);
    logic [30:0] obs, exp;
    obs = {seg_en, grant, sign, point, data};
    exp = {en, gr, s, p, d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed en=%b grant=%b data=%0d point=%b sign=%b, expected en=%b grant=%b data=%0d point=%b sign=%b",
             tag, seg_en, grant, data, point, sign, en, gr, d, p, s);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 1'b0, 3'b000, 20'd0, 6'd0, 1'b0);
  endtask

  task automatic chk_src(input string tag, input int s);
    if (s == 0) chk(tag, 1'b1, 3'b001, 20'd4321, 6'b000010, 1'b1);
    else if (s == 1) chk(tag, 1'b1, 3'b010, 20'd200, 6'b000100, 1'b0);
    else chk(tag, 1'b1, 3'b100, 20'd300, 6'b100000, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 chk_zero("reset_async");
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req = 3'b000;
    data_0 = 20'd4321; point_0 = 6'b000010; sign_0 = 1'b1;
    data_1 = 20'd200;  point_1 = 6'b000100; sign_1 = 1'b0;
    data_2 = 20'd300;  point_2 = 6'b100000; sign_2 = 1'b1;
    step();
    step();
    chk_zero("reset_state");
    #3 sys_rst_n = 1'b1;
    step();
    chk_zero("idle_no_req");
    // single source holds the display indefinitely
    req = 3'b001;
    step();
    chk_src("single_first", 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_src("single_hold", 0);
    end
    // rotation from a fresh reset: 0, 1, 2, 0 with 3-cycle gaps
    do_reset();
    req = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) begin
        step();
        chk_src("rot_show", r);
      end
      for (int k = 0; k < 3; k++) begin
        step();
        chk_zero("rot_blank");
      end
    end
    step();
    chk_src("rot_wrap", 0);
    // early owner drop at dwell 2
    step();
    chk_src("drop_dwell1", 0);
    step();
    chk_src("drop_dwell2", 0);
    req = 3'b110;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_zero("drop_blank");
    end
    step();
    chk_src("drop_next", 1);
    // owner drops, then everyone drops during the gap: IDLE after search
    req = 3'b101;
    step();
    chk_zero("gap_blank0");
    req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_zero("gap_to_idle");
    end
    req = 3'b100;
    step();
    chk_src("idle_regrant", 2);
    // simultaneous owner drop and dwell expiry
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_src("sim_show", 0);
    end
    req = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_zero("sim_blank");
    end
    step();
    chk_src("sim_next", 1);
    // clamp of the granted value
    data_1 = 20'd1_048_575;
    step();
    chk("clamp_max", 1'b1, 3'b010, 20'd999_999, 6'b000100, 1'b0);
    data_1 = 20'd1_000_000;
    step();
    chk("clamp_edge", 1'b1, 3'b010, 20'd999_999, 6'b000100, 1'b0);
    data_1 = 20'd999_999;
    step();
    chk("clamp_exact", 1'b1, 3'b010, 20'd999_999, 6'b000100, 1'b0);
    data_1 = 20'd0;
    step();
    chk("clamp_zero", 1'b1, 3'b010, 20'd0, 6'b000100, 1'b0);
    // asynchronous reset in the middle of SHOW
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    req = 3'b100;
    #2 sys_rst_n = 1'b1;
    step();
    chk_src("post_reset", 2);
    step();
    chk_src("post_reset_hold", 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
